// File: rtl/vend_credit_ctrl.sv
// Vend controller: converts BCD credit to binary, checks it against the selected
// item price, runs the dispenser handshake, pays change as pulses and clears the counters.
module vend_credit_ctrl #(
  parameter logic [7:0]  PRICE_0 = 8'd25,
  parameter logic [7:0]  PRICE_1 = 8'd40,
  parameter logic [7:0]  PRICE_2 = 8'd55,
  parameter logic [7:0]  PRICE_3 = 8'd75,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] credit_ones,
  input  logic [3:0] credit_tens,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic       vend_req,
  output logic [1:0] vend_item,
  output logic       change_pulse,
  output logic       cnt_clr,
  output logic       coin_inhibit,
  output logic       err_insufficient,
  output logic       vend_fault
);

  typedef enum logic [2:0] {IDLE, CHECK, VEND, CHANGE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  credit;
  logic [7:0]  price;
  logic [7:0]  credit_lat_q, credit_lat_d;
  logic [7:0]  change_amt_q, change_amt_d;
  logic [1:0]  vend_item_q, vend_item_d;
  logic [15:0] timer_q, timer_d;
  logic        phase_q, phase_d;

  // 10*tens computed as 8*tens + 2*tens
  assign credit = ({4'b0, credit_tens} << 3) + ({4'b0, credit_tens} << 1) + {4'b0, credit_ones};

  always_comb begin
    case (vend_item_q)
      2'd0:    price = PRICE_0;
      2'd1:    price = PRICE_1;
      2'd2:    price = PRICE_2;
      default: price = PRICE_3;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    credit_lat_d     = credit_lat_q;
    change_amt_d     = change_amt_q;
    vend_item_d      = vend_item_q;
    timer_d          = '0;
    phase_d          = 1'b0;
    vend_req         = 1'b0;
    change_pulse     = 1'b0;
    cnt_clr          = 1'b0;
    err_insufficient = 1'b0;
    vend_fault       = 1'b0;
    coin_inhibit     = (state_q != IDLE);
    vend_item        = vend_item_q;

    case (state_q)
      IDLE: begin
        if (cancel) begin
          if (credit != '0) begin
            credit_lat_d = credit;
            change_amt_d = credit;
            state_d      = CHANGE;
          end
        end else if (sel_valid) begin
          vend_item_d  = sel_item;
          credit_lat_d = credit;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (credit_lat_q >= price) begin
          change_amt_d = credit_lat_q - price;
          state_d      = VEND;
        end else begin
          err_insufficient = 1'b1;
          state_d          = IDLE;
        end
      end
      VEND: begin
        vend_req = 1'b1;
        timer_d  = timer_q + 16'd1;
        // ack takes priority over a coincident timeout
        if (vend_ack) begin
          timer_d = '0;
          state_d = (change_amt_q != '0) ? CHANGE : CLEAR;
        end else if (timer_q == TIMEOUT - 16'd1) begin
          vend_fault   = 1'b1;
          change_amt_d = credit_lat_q;
          timer_d      = '0;
          state_d      = CHANGE;
        end
      end
      CHANGE: begin
        if (change_amt_q == '0) begin
          state_d = CLEAR;
        end else if (!phase_q) begin
          change_pulse = 1'b1;
          change_amt_d = change_amt_q - 8'd1;
          phase_d      = 1'b1;
          if (change_amt_q == 8'd1) state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_lat_q <= '0;
      change_amt_q <= '0;
      vend_item_q  <= '0;
      timer_q      <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_lat_q <= credit_lat_d;
      change_amt_q <= change_amt_d;
      vend_item_q  <= vend_item_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_vend_credit_ctrl;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] credit_ones, credit_tens;
  logic       sel_valid, cancel, vend_ack;
  logic [1:0] sel_item;
  logic       vend_req, change_pulse, cnt_clr, coin_inhibit, err_insufficient, vend_fault;
  logic [1:0] vend_item;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int vreq; int pulses; int clr; int err; int fault; int inh;
  } exp_t;

  // observations from the last transaction
  int o_vreq, o_pulses, o_clr, o_err, o_fault, o_inh;
  int o_first_vreq, o_last_vreq, o_fault_cyc, o_err_cyc, o_gap_bad, o_item_bad;

  vend_credit_ctrl #(.TIMEOUT(16'(TMO))) dut (
    .clk(clk), .rst(rst), .credit_ones(credit_ones), .credit_tens(credit_tens),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .vend_ack(vend_ack),
    .vend_req(vend_req), .vend_item(vend_item), .change_pulse(change_pulse),
    .cnt_clr(cnt_clr), .coin_inhibit(coin_inhibit),
    .err_insufficient(err_insufficient), .vend_fault(vend_fault)
  );

  always #5 clk = ~clk;

  function automatic int price_of(input int item);
    case (item)
      0:       return 25;
      1:       return 40;
      2:       return 55;
      default: return 75;
    endcase
  endfunction

  // d = index of the VEND cycle in which the dispenser acks
  function automatic exp_t model(input int credit, input int item, input bit can,
                                 input bit sel, input int d);
    exp_t e;
    int   p;
    e.vreq = 0; e.pulses = 0; e.clr = 0; e.err = 0; e.fault = 0; e.inh = 0;
    p = price_of(item);
    if (can) begin
      if (credit > 0) begin
        e.pulses = credit; e.clr = 1; e.inh = 2 * credit;
      end
    end else if (sel) begin
      if (credit < p) begin
        e.err = 1; e.inh = 1;
      end else begin
        if (d <= TMO - 1) begin
          e.vreq = d + 1; e.pulses = credit - p;
        end else begin
          e.vreq = TMO; e.fault = 1; e.pulses = credit;
        end
        e.clr = 1;
        e.inh = 1 + e.vreq + ((e.pulses > 0) ? 2 * e.pulses - 1 : 0) + 1;
      end
    end
    return e;
  endfunction

  task automatic drive_txn(input int tens, input int ones, input int item,
                           input bit can, input bit sel, input int d);
    int cyc;
    int last_pulse;
    bit done;
    o_vreq = 0; o_pulses = 0; o_clr = 0; o_err = 0; o_fault = 0; o_inh = 0;
    o_first_vreq = -1; o_last_vreq = -1; o_fault_cyc = -1; o_err_cyc = -1;
    o_gap_bad = 0; o_item_bad = 0;
    last_pulse = -10; done = 1'b0; cyc = 0;
    @(negedge clk);
    credit_tens = 4'(tens); credit_ones = 4'(ones); sel_item = 2'(item);
    cancel = can; sel_valid = sel;
    while (!done && cyc < 400) begin
      if (cyc == 1) begin sel_valid = 1'b0; cancel = 1'b0; end
      vend_ack = vend_req && (o_vreq == d);
      #1;
      if (vend_req) begin
        if (o_first_vreq < 0) o_first_vreq = cyc;
        o_last_vreq = cyc; o_vreq++;
        if (vend_item !== 2'(item)) o_item_bad++;
      end
      if (change_pulse) begin
        if (o_pulses > 0 && cyc != last_pulse + 2) o_gap_bad++;
        last_pulse = cyc; o_pulses++;
      end
      if (cnt_clr) o_clr++;
      if (err_insufficient) begin o_err++; o_err_cyc = cyc; end
      if (vend_fault) begin o_fault++; o_fault_cyc = cyc; end
      if (coin_inhibit) o_inh++;
      else if (cyc > 0) done = 1'b1;
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    vend_ack = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
    n_total++;
    if (!done) $display("FAIL txn_bound: transaction still busy after %0d cycles, required return to idle", cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_total++;
    if ({vend_req, change_pulse, cnt_clr, coin_inhibit, err_insufficient, vend_fault, vend_item} !== 8'b0)
      $display("FAIL reset_outputs: got %b required 00000000",
               {vend_req, change_pulse, cnt_clr, coin_inhibit, err_insufficient, vend_fault, vend_item});
    else n_pass++;
  endtask

  task automatic test_exact_change();
    exp_t e;
    e = model(25, 0, 1'b0, 1'b1, 3);
    drive_txn(2, 5, 0, 1'b0, 1'b1, 3);
    n_total++; if (o_first_vreq !== 2) $display("FAIL exact_latency: got %0d required 2", o_first_vreq); else n_pass++;
    n_total++; if (o_vreq !== e.vreq) $display("FAIL exact_vreq: got %0d required %0d", o_vreq, e.vreq); else n_pass++;
    n_total++; if (o_pulses !== 0) $display("FAIL exact_pulses: got %0d required 0", o_pulses); else n_pass++;
    n_total++; if (o_clr !== 1) $display("FAIL exact_clr: got %0d required 1", o_clr); else n_pass++;
    n_total++; if (o_inh !== e.inh) $display("FAIL exact_inhibit: got %0d required %0d", o_inh, e.inh); else n_pass++;
  endtask

  task automatic test_change_payout();
    exp_t e;
    e = model(47, 1, 1'b0, 1'b1, 5);
    drive_txn(4, 7, 1, 1'b0, 1'b1, 5);
    n_total++; if (o_pulses !== 7) $display("FAIL payout_pulses: got %0d required 7", o_pulses); else n_pass++;
    n_total++; if (o_gap_bad !== 0) $display("FAIL payout_spacing: got %0d bad gaps required 0", o_gap_bad); else n_pass++;
    n_total++; if (o_clr !== e.clr) $display("FAIL payout_clr: got %0d required %0d", o_clr, e.clr); else n_pass++;
    n_total++; if (o_inh !== e.inh) $display("FAIL payout_inhibit: got %0d required %0d", o_inh, e.inh); else n_pass++;
    n_total++; if (o_item_bad !== 0) $display("FAIL payout_item: got %0d bad cycles required 0", o_item_bad); else n_pass++;
  endtask

  task automatic test_insufficient();
    drive_txn(3, 0, 3, 1'b0, 1'b1, 0);
    n_total++; if (o_err !== 1) $display("FAIL insuff_err: got %0d required 1", o_err); else n_pass++;
    n_total++; if (o_err_cyc !== 1) $display("FAIL insuff_err_cycle: got %0d required 1", o_err_cyc); else n_pass++;
    n_total++; if (o_vreq !== 0) $display("FAIL insuff_vreq: got %0d required 0", o_vreq); else n_pass++;
    n_total++; if (o_clr !== 0) $display("FAIL insuff_clr: got %0d required 0", o_clr); else n_pass++;
    n_total++; if (o_inh !== 1) $display("FAIL insuff_inhibit: got %0d required 1", o_inh); else n_pass++;
  endtask

  task automatic test_timeout();
    drive_txn(6, 0, 2, 1'b0, 1'b1, 1000);
    n_total++; if (o_fault !== 1) $display("FAIL tmo_fault: got %0d required 1", o_fault); else n_pass++;
    n_total++; if (o_vreq !== TMO) $display("FAIL tmo_vreq: got %0d required %0d", o_vreq, TMO); else n_pass++;
    n_total++; if (o_fault_cyc !== o_last_vreq || o_fault_cyc < 0) $display("FAIL tmo_fault_cycle: got %0d required %0d", o_fault_cyc, o_last_vreq); else n_pass++;
    n_total++; if (o_pulses !== 60) $display("FAIL tmo_refund: got %0d required 60", o_pulses); else n_pass++;
    n_total++; if (o_clr !== 1) $display("FAIL tmo_clr: got %0d required 1", o_clr); else n_pass++;
  endtask

  task automatic test_ack_timeout_tie();
    drive_txn(10, 10, 3, 1'b0, 1'b1, TMO - 1);
    n_total++; if (o_fault !== 0) $display("FAIL tie_fault: got %0d required 0", o_fault); else n_pass++;
    n_total++; if (o_vreq !== TMO) $display("FAIL tie_vreq: got %0d required %0d", o_vreq, TMO); else n_pass++;
    n_total++; if (o_pulses !== 35) $display("FAIL tie_change: got %0d required 35", o_pulses); else n_pass++;
  endtask

  task automatic test_cancel();
    drive_txn(1, 2, 1, 1'b1, 1'b1, 0);
    n_total++; if (o_pulses !== 12) $display("FAIL cancel_pulses: got %0d required 12", o_pulses); else n_pass++;
    n_total++; if (o_vreq !== 0) $display("FAIL cancel_vreq: got %0d required 0", o_vreq); else n_pass++;
    n_total++; if (o_clr !== 1) $display("FAIL cancel_clr: got %0d required 1", o_clr); else n_pass++;
    drive_txn(0, 0, 0, 1'b1, 1'b0, 0);
    n_total++; if (o_pulses + o_clr + o_inh + o_vreq !== 0)
      $display("FAIL cancel_zero: got %0d output events required 0", o_pulses + o_clr + o_inh + o_vreq);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    int extra;
    seen = 0; extra = 0;
    @(negedge clk);
    credit_tens = 4'd1; credit_ones = 4'd0; cancel = 1'b1;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      @(negedge clk);
      cancel = 1'b0;
      #1;
      if (change_pulse) seen++;
    end
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({vend_req, change_pulse, cnt_clr, coin_inhibit, err_insufficient, vend_fault, vend_item} !== 8'b0)
      $display("FAIL rst_mid_outputs: got %b required 00000000 (pulses before rst %0d)",
               {vend_req, change_pulse, cnt_clr, coin_inhibit, err_insufficient, vend_fault, vend_item}, seen);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (change_pulse || cnt_clr || coin_inhibit) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles required 0", extra); else n_pass++;
  endtask

  task automatic test_random();
    exp_t e;
    int   t, o, it, d;
    bit   can, sel;
    for (int k = 0; k < 40; k++) begin
      t = int'($urandom_range(0, 10));
      o = int'($urandom_range(0, 10));
      it = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 11));
      can = ($urandom_range(0, 3) == 0);
      sel = can ? 1'($urandom_range(0, 1)) : 1'b1;
      e = model(10 * t + o, it, can, sel, d);
      drive_txn(t, o, it, can, sel, d);
      n_total++; if (o_vreq !== e.vreq) $display("FAIL rnd_vreq[%0d]: got %0d required %0d", k, o_vreq, e.vreq); else n_pass++;
      n_total++; if (o_pulses !== e.pulses) $display("FAIL rnd_pulses[%0d]: got %0d required %0d", k, o_pulses, e.pulses); else n_pass++;
      n_total++; if (o_clr !== e.clr) $display("FAIL rnd_clr[%0d]: got %0d required %0d", k, o_clr, e.clr); else n_pass++;
      n_total++; if (o_err !== e.err) $display("FAIL rnd_err[%0d]: got %0d required %0d", k, o_err, e.err); else n_pass++;
      n_total++; if (o_fault !== e.fault) $display("FAIL rnd_fault[%0d]: got %0d required %0d", k, o_fault, e.fault); else n_pass++;
      n_total++; if (o_inh !== e.inh) $display("FAIL rnd_inhibit[%0d]: got %0d required %0d", k, o_inh, e.inh); else n_pass++;
      n_total++; if (o_gap_bad + o_item_bad !== 0) $display("FAIL rnd_shape[%0d]: got %0d bad cycles required 0", k, o_gap_bad + o_item_bad); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    credit_ones = '0; credit_tens = '0; sel_valid = 1'b0; sel_item = '0;
    cancel = 1'b0; vend_ack = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_exact_change();
    test_change_payout();
    test_insufficient();
    test_timeout();
    test_ack_timeout_tie();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
